multicycle_control: RTL and testbench

//  Multi-cycle MIPS main control FSM; successor to the single-cycle opcode decoder.

---
 rtl/mc_ctrl_pkg.sv | 69 ++++++
 rtl/mc_wait_timer.sv | 29 ++
 rtl/multicycle_control.sv | 181 ++++++++++++++++++
 tb/tb_multicycle_control.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: FSM state
// encoding, opcode constants, alu_op / pc_src / alu_src_b codes, the
// bundled control-word struct, and the DECODE dispatch helper.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_RESET, ST_FETCH, ST_DECODE, ST_MEM_ADDR, ST_MEM_READ, ST_MEM_WB,
    ST_MEM_WRITE, ST_EXEC_R, ST_R_WB, ST_EXEC_I, ST_I_WB, ST_BRANCH,
    ST_JUMP, ST_ILLEGAL, ST_FAULT
  } state_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_SLTI = 6'b001010;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_IMM   = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       illegal;
    logic       fault;
  } ctrl_t;

  // Where DECODE goes for a given opcode; anything unrecognised traps so an
  // unknown opcode can never reach an execute state.
  function automatic state_e decode_op(input logic [5:0] op);
    case (op)
      OP_R:                             decode_op = ST_EXEC_R;
      OP_LW, OP_SW:                     decode_op = ST_MEM_ADDR;
      OP_BEQ, OP_BNE:                   decode_op = ST_BRANCH;
      OP_J:                             decode_op = ST_JUMP;
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: decode_op = ST_EXEC_I;
      default:                          decode_op = ST_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Saturating memory-wait counter.
//   i_clk      clock
//   i_reset    synchronous active-high reset (count -> 0)
//   i_clr      synchronous clear (state change)
//   i_inc      count one more wait cycle
//   o_expired  count has reached MAX_WAIT (never asserts when MAX_WAIT==0)
module mc_wait_timer #(
  parameter int WAIT_W   = 4,
  parameter int MAX_WAIT = 15
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_expired
);

  logic [WAIT_W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clr)
      r_count <= '0;
    else if (i_inc && (r_count != '1))  // saturate, never wrap
      r_count <= r_count + WAIT_W'(1);
  end

  assign o_expired = (MAX_WAIT != 0) && (r_count == WAIT_W'(MAX_WAIT));

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main control FSM.
// Sequences FETCH/DECODE/EXEC/MEM/WB per instruction, traps undefined
// opcodes and faults (sticky) when a memory access waits too long.
//   clk, reset         clock, synchronous active-high reset
//   opcode             IR[31:26], stable from DECODE to instruction end
//   mem_ready          memory accepted/completed the current access
//   pc_write/_cond     PC load (unconditional / on branch condition)
//   branch_ne          branch on zero==0 (bne) instead of zero==1
//   pc_src, iord       PC source select, memory address select
//   mem_read/mem_write memory requests; ir_write IR load
//   reg_dst, mem_to_reg, reg_write   register-file write path
//   alu_src_a/b, alu_op              ALU operand and operation select
//   illegal            one-cycle pulse on undefined opcode
//   fault              sticky memory timeout, cleared only by reset
module multicycle_control
  import mc_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 2,
  parameter int WAIT_W   = 4,
  parameter int MAX_WAIT = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                branch_ne,
  output logic [1:0]          pc_src,
  output logic                iord,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic                illegal,
  output logic                fault
);

  state_e     r_state;
  state_e     w_next;
  ctrl_t      w_ctl;
  logic [5:0] w_op;
  logic       w_expired;
  logic       w_wait_st;

  assign w_op = 6'(opcode);

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_RESET;
    else       r_state <= w_next;
  end

  // Only the three memory-handshake states accumulate wait cycles; any
  // state change restarts the count, so each access gets a fresh budget.
  assign w_wait_st = (r_state == ST_FETCH) || (r_state == ST_MEM_READ) ||
                     (r_state == ST_MEM_WRITE);

  mc_wait_timer #(.WAIT_W(WAIT_W), .MAX_WAIT(MAX_WAIT)) u_wait (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_clr     (w_next != r_state),
    .i_inc     (w_wait_st && !mem_ready),
    .o_expired (w_expired)
  );

  // Next state. In wait states mem_ready is tested before the timeout so a
  // handshake landing on the last allowed cycle still completes normally.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_RESET:     w_next = ST_FETCH;
      ST_FETCH:     if (mem_ready)      w_next = ST_DECODE;
                    else if (w_expired) w_next = ST_FAULT;
      ST_DECODE:    w_next = decode_op(w_op);
      ST_MEM_ADDR:  w_next = (w_op == OP_LW) ? ST_MEM_READ : ST_MEM_WRITE;
      ST_MEM_READ:  if (mem_ready)      w_next = ST_MEM_WB;
                    else if (w_expired) w_next = ST_FAULT;
      ST_MEM_WRITE: if (mem_ready)      w_next = ST_FETCH;
                    else if (w_expired) w_next = ST_FAULT;
      ST_EXEC_R:    w_next = ST_R_WB;
      ST_EXEC_I:    w_next = ST_I_WB;
      ST_MEM_WB, ST_R_WB, ST_I_WB,
      ST_BRANCH, ST_JUMP, ST_ILLEGAL:
                    w_next = ST_FETCH;
      ST_FAULT:     w_next = ST_FAULT;
      default:      w_next = ST_RESET;
    endcase
  end

  // Output decode: Moore, except the FETCH ir_write/pc_write which follow
  // mem_ready so IR and PC+4 load exactly on the completing cycle.
  always_comb begin
    w_ctl = '0;
    case (r_state)
      ST_FETCH: begin
        w_ctl.mem_read  = 1'b1;
        w_ctl.alu_src_b = SRCB_FOUR;
        w_ctl.alu_op    = ALU_ADD;
        w_ctl.ir_write  = mem_ready;
        w_ctl.pc_write  = mem_ready;
      end
      ST_DECODE: begin
        w_ctl.alu_src_b = SRCB_IMM_SH2;  // precompute branch target
        w_ctl.alu_op    = ALU_ADD;
      end
      ST_MEM_ADDR: begin
        w_ctl.alu_src_a = 1'b1;
        w_ctl.alu_src_b = SRCB_IMM;
        w_ctl.alu_op    = ALU_ADD;
      end
      ST_MEM_READ: begin
        w_ctl.mem_read = 1'b1;
        w_ctl.iord     = 1'b1;
      end
      ST_MEM_WB: begin
        w_ctl.mem_to_reg = 1'b1;
        w_ctl.reg_write  = 1'b1;
      end
      ST_MEM_WRITE: begin
        w_ctl.mem_write = 1'b1;
        w_ctl.iord      = 1'b1;
      end
      ST_EXEC_R: begin
        w_ctl.alu_src_a = 1'b1;
        w_ctl.alu_src_b = SRCB_REG;
        w_ctl.alu_op    = ALU_FUNCT;
      end
      ST_R_WB: begin
        w_ctl.reg_dst   = 1'b1;
        w_ctl.reg_write = 1'b1;
      end
      ST_EXEC_I: begin
        w_ctl.alu_src_a = 1'b1;
        w_ctl.alu_src_b = SRCB_IMM;
        w_ctl.alu_op    = ALU_IMM;
      end
      ST_I_WB: begin
        w_ctl.reg_write = 1'b1;
      end
      ST_BRANCH: begin
        w_ctl.alu_src_a     = 1'b1;
        w_ctl.alu_src_b     = SRCB_REG;
        w_ctl.alu_op        = ALU_SUB;
        w_ctl.pc_write_cond = 1'b1;
        w_ctl.pc_src        = PCSRC_ALUOUT;
        w_ctl.branch_ne     = (w_op == OP_BNE);
      end
      ST_JUMP: begin
        w_ctl.pc_write = 1'b1;
        w_ctl.pc_src   = PCSRC_JUMP;
      end
      ST_ILLEGAL: w_ctl.illegal = 1'b1;  // PC already advanced in FETCH
      ST_FAULT:   w_ctl.fault   = 1'b1;
      default:    w_ctl = '0;
    endcase
  end

  assign pc_write      = w_ctl.pc_write;
  assign pc_write_cond = w_ctl.pc_write_cond;
  assign branch_ne     = w_ctl.branch_ne;
  assign pc_src        = w_ctl.pc_src;
  assign iord          = w_ctl.iord;
  assign mem_read      = w_ctl.mem_read;
  assign mem_write     = w_ctl.mem_write;
  assign ir_write      = w_ctl.ir_write;
  assign reg_dst       = w_ctl.reg_dst;
  assign mem_to_reg    = w_ctl.mem_to_reg;
  assign reg_write     = w_ctl.reg_write;
  assign alu_src_a     = w_ctl.alu_src_a;
  assign alu_src_b     = w_ctl.alu_src_b;
  assign alu_op        = ALUOP_W'(w_ctl.alu_op);
  assign illegal       = w_ctl.illegal;
  assign fault         = w_ctl.fault;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: each cycle's stimulus and the
// control word the spec demands for that cycle are queued together, then
// replayed and compared one cycle at a time.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write;
  logic       ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, illegal, fault;
  logic [1:0] pc_src, alu_src_b, alu_op;

  always #5 clk = ~clk;

  multicycle_control #(.OPCODE_W(6), .ALUOP_W(2), .WAIT_W(4), .MAX_WAIT(15)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
    .pc_src(pc_src), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .illegal(illegal), .fault(fault)
  );

  typedef struct packed {
    logic       fault, illegal;
    logic [1:0] alu_op, alu_src_b;
    logic       alu_src_a, reg_write, mem_to_reg, reg_dst, ir_write;
    logic       mem_write, mem_read, iord;
    logic [1:0] pc_src;
    logic       branch_ne, pc_write_cond, pc_write;
  } ctl_t;

  typedef struct packed { logic rst; logic rdy; logic [5:0] op; } stim_t;

  typedef enum int {
    S_RST, S_FETCH, S_DECODE, S_MADDR, S_MREAD, S_MWB, S_MWRITE,
    S_EXR, S_RWB, S_EXI, S_IWB, S_BR, S_JMP, S_ILL, S_FLT
  } bst_t;

  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, J = 6'b000010;
  localparam logic [5:0] ADDI = 6'b001000, ANDI = 6'b001100;
  localparam logic [5:0] ORI = 6'b001101, SLTI = 6'b001010;

  ctl_t  got;
  assign got = {fault, illegal, alu_op, alu_src_b, alu_src_a, reg_write, mem_to_reg,
                reg_dst, ir_write, mem_write, mem_read, iord, pc_src, branch_ne,
                pc_write_cond, pc_write};

  ctl_t  exp_q[$];
  stim_t stim_q[$];
  string tag_q[$];
  int    n_checks = 0;
  int    n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Control word required in each state, straight from the state table.
  function automatic ctl_t exp_of(input bst_t st, input logic rdy, input logic [5:0] op);
    ctl_t c = '0;
    case (st)
      S_FETCH:  begin c.mem_read = 1; c.alu_src_b = 2'b01; c.ir_write = rdy; c.pc_write = rdy; end
      S_DECODE: c.alu_src_b = 2'b11;
      S_MADDR:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      S_MREAD:  begin c.mem_read = 1; c.iord = 1; end
      S_MWB:    begin c.mem_to_reg = 1; c.reg_write = 1; end
      S_MWRITE: begin c.mem_write = 1; c.iord = 1; end
      S_EXR:    begin c.alu_src_a = 1; c.alu_op = 2'b10; end
      S_RWB:    begin c.reg_dst = 1; c.reg_write = 1; end
      S_EXI:    begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_op = 2'b11; end
      S_IWB:    c.reg_write = 1;
      S_BR:     begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_write_cond = 1;
                      c.pc_src = 2'b01; c.branch_ne = (op == BNE); end
      S_JMP:    begin c.pc_write = 1; c.pc_src = 2'b10; end
      S_ILL:    c.illegal = 1;
      S_FLT:    c.fault = 1;
      default:  c = '0;
    endcase
    return c;
  endfunction

  task automatic push(input string tag, input logic rst, input logic rdy,
                      input logic [5:0] op, input bst_t st);
    stim_q.push_back('{rst: rst, rdy: rdy, op: op});
    exp_q.push_back(exp_of(st, rdy, op));
    tag_q.push_back(tag);
  endtask

  // One full instruction with memory always ready.
  task automatic run_op(input string tag, input logic [5:0] op);
    push(tag, 0, 1, op, S_FETCH);
    push(tag, 0, 1, op, S_DECODE);
    case (op)
      R:                     begin push(tag, 0, 1, op, S_EXR);   push(tag, 0, 1, op, S_RWB); end
      LW:                    begin push(tag, 0, 1, op, S_MADDR); push(tag, 0, 1, op, S_MREAD);
                                   push(tag, 0, 1, op, S_MWB); end
      SW:                    begin push(tag, 0, 1, op, S_MADDR); push(tag, 0, 1, op, S_MWRITE); end
      BEQ, BNE:              push(tag, 0, 1, op, S_BR);
      J:                     push(tag, 0, 1, op, S_JMP);
      ADDI, ANDI, ORI, SLTI: begin push(tag, 0, 1, op, S_EXI); push(tag, 0, 1, op, S_IWB); end
      default:               push(tag, 0, 1, op, S_ILL);
    endcase
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete within time limit");
    $fatal(1);
  end

  initial begin
    stim_t s;
    reset = 1'b1; mem_ready = 1'b0; opcode = '0;
    repeat (2) @(posedge clk);

    // reset asserted 3 cycles in the middle of a lw, then released
    push("rst_init", 0, 1, LW, S_RST);
    push("lw_abort", 0, 1, LW, S_FETCH);
    push("lw_abort", 0, 1, LW, S_DECODE);
    push("rst_mid",  1, 1, LW, S_MADDR);
    push("rst_hold", 1, 1, LW, S_RST);
    push("rst_hold", 1, 1, LW, S_RST);
    push("rst_rel",  0, 1, LW, S_RST);

    // lw with three wait cycles in MEM_READ: 8 cycles total
    push("lw_wait", 0, 1, LW, S_FETCH);
    push("lw_wait", 0, 1, LW, S_DECODE);
    push("lw_wait", 0, 1, LW, S_MADDR);
    for (int i = 0; i < 3; i++) push("lw_wait", 0, 0, LW, S_MREAD);
    push("lw_wait", 0, 1, LW, S_MREAD);
    push("lw_wait", 0, 1, LW, S_MWB);

    run_op("r_type", R);
    run_op("sw",     SW);
    run_op("addi",   ADDI);
    run_op("andi",   ANDI);
    run_op("ori",    ORI);
    run_op("slti",   SLTI);
    run_op("bne",    BNE);
    run_op("beq",    BEQ);
    run_op("jump",   J);
    run_op("ill_3f", 6'b111111);
    run_op("ill_03", 6'b000011);
    run_op("lw",     LW);

    // ready arrives exactly at count==MAX_WAIT: normal fetch, no fault
    for (int i = 0; i < 15; i++) push("wait_edge", 0, 0, R, S_FETCH);
    push("wait_edge", 0, 1, R, S_FETCH);
    push("wait_edge", 0, 1, R, S_DECODE);
    push("wait_edge", 0, 1, R, S_EXR);
    push("wait_edge", 0, 1, R, S_RWB);

    // 16 wait cycles in FETCH -> FAULT, sticky until reset
    for (int i = 0; i < 16; i++) push("timeout", 0, 0, J, S_FETCH);
    for (int i = 0; i < 3; i++)  push("fault_sticky", 0, 1, J, S_FLT);
    push("fault_rst", 1, 1, J, S_FLT);
    push("fault_rst", 0, 1, J, S_RST);
    run_op("post_fault", J);

    while (stim_q.size() > 0) begin
      @(negedge clk);
      s = stim_q.pop_front();
      reset = s.rst; mem_ready = s.rdy; opcode = s.op;
      #1;
      check(tag_q.pop_front(), 32'(got), 32'(exp_q.pop_front()));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
